memory_request_arbiter: RTL and testbench

Multi-port front end for the memory latency injector with contention. It arbitrates up to NUM_PORTS requesters onto the injector's single request port using round-robin with an optional strict-priority port. It caps outstanding requests per port and records the issuing port of every request in an order FIFO. Because the injector completes requests in issue order, each response is routed back to the port that issued it.

---
 rtl/memory_request_arbiter.sv | 164 ++++++++++++++++
 tb/tb_memory_request_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_request_arbiter.sv
// Round-robin / strict-priority arbiter in front of the in-order memory latency injector.
// Tracks per-port outstanding requests and routes in-order responses back through an order FIFO.
module memory_request_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_W      = 2,
    parameter int SIZE_WIDTH  = 16,
    parameter int ORDER_DEPTH = 8,
    parameter int OUT_W       = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            up_req_valid,
    input  logic [NUM_PORTS-1:0]            up_req_is_dram,
    input  logic [NUM_PORTS*SIZE_WIDTH-1:0] up_req_size_bytes,
    output logic [NUM_PORTS-1:0]            up_req_ready,
    output logic [NUM_PORTS-1:0]            up_resp_valid,
    output logic [SIZE_WIDTH-1:0]           up_resp_size_bytes,
    output logic                            mem_req_valid,
    output logic                            mem_req_is_dram,
    output logic [SIZE_WIDTH-1:0]           mem_req_size_bytes,
    input  logic                            mem_req_ready,
    input  logic                            mem_resp_valid,
    input  logic [SIZE_WIDTH-1:0]           mem_resp_size_bytes,
    input  logic                            cfg_enable,
    input  logic                            cfg_prio_en,
    input  logic [PORT_W-1:0]               cfg_prio_port,
    input  logic [OUT_W-1:0]                cfg_max_outstanding,
    output logic [31:0]                     grant_count,
    output logic [31:0]                     order_full_stall_cycles,
    output logic [$clog2(ORDER_DEPTH):0]    outstanding_total,
    output logic                            err_resp_underflow
);
    localparam int AW    = $clog2(ORDER_DEPTH);
    localparam int OCC_W = AW + 1;

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid never waits for ready, and a staged mem_req holds all fields until accepted.

    logic [PORT_W-1:0]    rr_ptr;
    logic [PORT_W-1:0]    staged_port;
    logic [OUT_W-1:0]     out_cnt [NUM_PORTS];
    logic [PORT_W-1:0]    fifo_mem [ORDER_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic                 slot_free;
    logic                 fifo_ok;
    logic                 push;
    logic                 pop;
    logic                 prio_hit;
    logic                 any_grant;
    logic                 stall_cond;
    logic [NUM_PORTS-1:0] cap_ok;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [PORT_W-1:0]    grant_idx;
    logic [PORT_W-1:0]    head;
    int                   rr_idx;

    assign slot_free = !mem_req_valid || mem_req_ready;
    // The staged request still needs a FIFO slot, so it is reserved ahead of any new grant.
    assign fifo_ok   = (OCC_W'(ORDER_DEPTH) - occ) > OCC_W'(mem_req_valid);
    assign push      = mem_req_valid && mem_req_ready;
    assign pop       = mem_resp_valid && (occ != '0);
    assign head      = fifo_mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cap_ok[i] = (cfg_max_outstanding == '0) || (out_cnt[i] < cfg_max_outstanding);
        end
        eligible   = up_req_valid & cap_ok & {NUM_PORTS{cfg_enable && slot_free && fifo_ok && reset_n}};
        stall_cond = cfg_enable && slot_free && !fifo_ok && (|(up_req_valid & cap_ok));
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        prio_hit  = 1'b0;
        any_grant = 1'b0;
        rr_idx    = 0;
        if (cfg_prio_en && (int'(cfg_prio_port) < NUM_PORTS) && eligible[cfg_prio_port]) begin
            prio_hit  = 1'b1;
            any_grant = 1'b1;
            grant_idx = cfg_prio_port;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
                if (!any_grant && eligible[rr_idx]) begin
                    any_grant = 1'b1;
                    grant_idx = PORT_W'(rr_idx);
                end
            end
        end
        if (any_grant) grant[grant_idx] = 1'b1;
    end

    assign up_req_ready      = grant;
    assign outstanding_total = occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_valid           <= 1'b0;
            mem_req_is_dram         <= 1'b0;
            mem_req_size_bytes      <= '0;
            staged_port             <= '0;
            rr_ptr                  <= '0;
            grant_count             <= '0;
            order_full_stall_cycles <= '0;
        end else begin
            if (any_grant) begin
                mem_req_valid      <= 1'b1;
                mem_req_is_dram    <= up_req_is_dram[grant_idx];
                mem_req_size_bytes <= up_req_size_bytes[grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
                staged_port        <= grant_idx;
                grant_count        <= grant_count + 32'd1;
                if (!prio_hit) begin
                    rr_ptr <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                end
            end else if (mem_req_ready) begin
                mem_req_valid <= 1'b0;
            end
            if (stall_cond) order_full_stall_cycles <= order_full_stall_cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= staged_port;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            occ                <= '0;
            up_resp_valid      <= '0;
            up_resp_size_bytes <= '0;
            err_resp_underflow <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) out_cnt[i] <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            up_resp_valid <= '0;
            if (pop) begin
                up_resp_valid      <= NUM_PORTS'(1) << head;
                up_resp_size_bytes <= mem_resp_size_bytes;
            end
            if (mem_resp_valid && (occ == '0)) err_resp_underflow <= 1'b1;
            // A grant and a response to the same port cancel out.
            for (int i = 0; i < NUM_PORTS; i++) begin
                case ({grant[i], pop && (head == PORT_W'(i))})
                    2'b10:   out_cnt[i] <= out_cnt[i] + 1'b1;
                    2'b01:   out_cnt[i] <= out_cnt[i] - 1'b1;
                    default: out_cnt[i] <= out_cnt[i];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_memory_request_arbiter.sv
// Randomized and directed bench for memory_request_arbiter against a queue-based reference model.
module tb_memory_request_arbiter;
    localparam int NUM_PORTS   = 4;
    localparam int PORT_W      = 2;
    localparam int SIZE_WIDTH  = 16;
    localparam int ORDER_DEPTH = 8;
    localparam int OUT_W       = 4;

    logic                            clk;
    logic                            reset_n;
    logic [NUM_PORTS-1:0]            up_req_valid;
    logic [NUM_PORTS-1:0]            up_req_is_dram;
    logic [NUM_PORTS*SIZE_WIDTH-1:0] up_req_size_bytes;
    logic [NUM_PORTS-1:0]            up_req_ready;
    logic [NUM_PORTS-1:0]            up_resp_valid;
    logic [SIZE_WIDTH-1:0]           up_resp_size_bytes;
    logic                            mem_req_valid;
    logic                            mem_req_is_dram;
    logic [SIZE_WIDTH-1:0]           mem_req_size_bytes;
    logic                            mem_req_ready;
    logic                            mem_resp_valid;
    logic [SIZE_WIDTH-1:0]           mem_resp_size_bytes;
    logic                            cfg_enable;
    logic                            cfg_prio_en;
    logic [PORT_W-1:0]               cfg_prio_port;
    logic [OUT_W-1:0]                cfg_max_outstanding;
    logic [31:0]                     grant_count;
    logic [31:0]                     order_full_stall_cycles;
    logic [$clog2(ORDER_DEPTH):0]    outstanding_total;
    logic                            err_resp_underflow;

    memory_request_arbiter #(
        .NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W), .SIZE_WIDTH(SIZE_WIDTH),
        .ORDER_DEPTH(ORDER_DEPTH), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .up_req_valid(up_req_valid), .up_req_is_dram(up_req_is_dram),
        .up_req_size_bytes(up_req_size_bytes), .up_req_ready(up_req_ready),
        .up_resp_valid(up_resp_valid), .up_resp_size_bytes(up_resp_size_bytes),
        .mem_req_valid(mem_req_valid), .mem_req_is_dram(mem_req_is_dram),
        .mem_req_size_bytes(mem_req_size_bytes), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_size_bytes(mem_resp_size_bytes),
        .cfg_enable(cfg_enable), .cfg_prio_en(cfg_prio_en), .cfg_prio_port(cfg_prio_port),
        .cfg_max_outstanding(cfg_max_outstanding), .grant_count(grant_count),
        .order_full_stall_cycles(order_full_stall_cycles),
        .outstanding_total(outstanding_total), .err_resp_underflow(err_resp_underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PORT_W-1:0]     exp_q[$];
    int                    m_rr;
    int                    m_cnt [NUM_PORTS];
    bit                    m_valid;
    int                    m_port;
    logic                  m_dram;
    logic [SIZE_WIDTH-1:0] m_size;
    logic [31:0]           m_gc;
    logic [31:0]           m_stall;
    logic [NUM_PORTS-1:0]  m_resp_v;
    logic [SIZE_WIDTH-1:0] m_resp_size;
    bit                    m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr = 0;
        for (int i = 0; i < NUM_PORTS; i++) m_cnt[i] = 0;
        m_valid = 0; m_port = 0; m_dram = 0; m_size = '0;
        m_gc = '0; m_stall = '0; m_resp_v = '0; m_resp_size = '0; m_err = 0;
    endtask

    function automatic bit cap_allows(int p);
        return (cfg_max_outstanding == 0) || (m_cnt[p] < int'(cfg_max_outstanding));
    endfunction

    function automatic bit space_ok();
        return (ORDER_DEPTH - exp_q.size()) > (m_valid ? 1 : 0);
    endfunction

    function automatic int exp_grant(output bit is_prio);
        bit can;
        bit elig [NUM_PORTS];
        can = reset_n && cfg_enable && (!m_valid || mem_req_ready) && space_ok();
        for (int i = 0; i < NUM_PORTS; i++) elig[i] = can && up_req_valid[i] && cap_allows(i);
        is_prio = 0;
        if (cfg_prio_en && int'(cfg_prio_port) < NUM_PORTS && elig[cfg_prio_port]) begin
            is_prio = 1;
            return int'(cfg_prio_port);
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (elig[(m_rr + k) % NUM_PORTS]) return (m_rr + k) % NUM_PORTS;
        end
        return -1;
    endfunction

    task automatic model_step(input int g, input bit pr);
        bit blocked_req;
        int p;
        blocked_req = 0;
        for (int i = 0; i < NUM_PORTS; i++) if (up_req_valid[i] && cap_allows(i)) blocked_req = 1;
        if (cfg_enable && (!m_valid || mem_req_ready) && !space_ok() && blocked_req) m_stall++;
        m_resp_v = '0;
        if (mem_resp_valid) begin
            if (exp_q.size() > 0) begin
                p = int'(exp_q.pop_front());
                m_cnt[p]--;
                m_resp_v[p] = 1'b1;
                m_resp_size = mem_resp_size_bytes;
            end else begin
                m_err = 1;
            end
        end
        if (m_valid && mem_req_ready) exp_q.push_back(PORT_W'(m_port));
        if (g >= 0) begin
            m_cnt[g]++;
            m_gc++;
            m_valid = 1;
            m_port  = g;
            m_dram  = up_req_is_dram[g];
            m_size  = up_req_size_bytes[g*SIZE_WIDTH +: SIZE_WIDTH];
            if (!pr) m_rr = (g + 1) % NUM_PORTS;
        end else if (mem_req_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock: compare DUT against model, advance model, step past the edge.
    task automatic run_cycle();
        int g;
        bit pr;
        #1;
        g = exp_grant(pr);
        check_val("grant", 32'(up_req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check_val("mem_req_valid", 32'(mem_req_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("mem_req_dram", 32'(mem_req_is_dram), 32'(m_dram));
            check_val("mem_req_size", 32'(mem_req_size_bytes), 32'(m_size));
        end
        check_val("resp_valid", 32'(up_resp_valid), 32'(m_resp_v));
        check_val("resp_size", 32'(up_resp_size_bytes), 32'(m_resp_size));
        check_val("grant_count", grant_count, m_gc);
        check_val("stall_cycles", order_full_stall_cycles, m_stall);
        check_val("outstanding", 32'(outstanding_total), 32'(exp_q.size()));
        check_val("underflow", 32'(err_resp_underflow), 32'(m_err));
        if (reset_n) model_step(g, pr);
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic randomize_payload();
        for (int i = 0; i < NUM_PORTS; i++) begin
            up_req_size_bytes[i*SIZE_WIDTH +: SIZE_WIDTH] = SIZE_WIDTH'($urandom_range(0, 65535));
            up_req_is_dram[i] = 1'($urandom_range(0, 1));
        end
        mem_resp_size_bytes = SIZE_WIDTH'($urandom_range(0, 65535));
    endtask

    task automatic drive_cycles(input logic [NUM_PORTS-1:0] v, input bit rdy, input bit resp, input int n);
        for (int c = 0; c < n; c++) begin
            randomize_payload();
            up_req_valid   = v;
            mem_req_ready  = rdy;
            mem_resp_valid = resp && (exp_q.size() > 0);
            run_cycle();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_valid) && n < 200) begin
            drive_cycles('0, 1'b1, 1'b1, 1);
            n++;
        end
        check_val("drain_bound", 32'(n < 200), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {27'(up_req_ready), 1'(up_resp_valid != 0), 1'(mem_req_valid),
                        1'(mem_req_is_dram), 1'(err_resp_underflow), 1'(up_resp_size_bytes != 0)}, 32'd0);
        check_val({tag, "_cnt"}, grant_count | order_full_stall_cycles | 32'(outstanding_total)
                                 | 32'(mem_req_size_bytes), 32'd0);
    endtask

    int gc0;

    initial begin
        reset_n = 1'b0;
        up_req_valid = '1; up_req_is_dram = '0; up_req_size_bytes = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_size_bytes = '0;
        cfg_enable = 1'b1; cfg_prio_en = 1'b0; cfg_prio_port = '0; cfg_max_outstanding = '0;
        model_reset();
        #2;
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Round-robin fairness
        drive_cycles('1, 1'b1, 1'b1, 8);
        check_val("rr_grant_count", grant_count, 32'd8);

        // Strict priority, then round-robin resumes from unchanged pointer
        cfg_prio_en = 1'b1; cfg_prio_port = 2'd2;
        drive_cycles('1, 1'b1, 1'b1, 6);
        drive_cycles(4'b1011, 1'b1, 1'b1, 5);
        cfg_prio_en = 1'b0;
        drain();

        // Outstanding cap
        cfg_max_outstanding = 4'd2;
        gc0 = int'(grant_count);
        drive_cycles(4'b0010, 1'b1, 1'b0, 6);
        check_val("cap_blocked", 32'(up_req_ready[1]), 32'd0);
        drive_cycles(4'b0010, 1'b1, 1'b1, 1);
        drive_cycles(4'b0010, 1'b1, 1'b0, 4);
        check_val("cap_grants", grant_count - 32'(gc0), 32'd3);
        cfg_max_outstanding = '0;
        drain();

        // Order FIFO full
        drive_cycles('1, 1'b1, 1'b0, 14);
        check_val("full_occ", 32'(outstanding_total), 32'd8);
        drain();

        // Response routing 3,0,3,1
        drive_cycles(4'b1000, 1'b1, 1'b0, 1);
        drive_cycles(4'b0001, 1'b1, 1'b0, 1);
        drive_cycles(4'b1000, 1'b1, 1'b0, 1);
        drive_cycles(4'b0010, 1'b1, 1'b0, 1);
        drive_cycles('0, 1'b1, 1'b0, 2);
        drive_cycles('0, 1'b1, 1'b1, 1);
        check_val("route0", 32'(up_resp_valid), 32'h8);
        drive_cycles('0, 1'b1, 1'b1, 1);
        check_val("route1", 32'(up_resp_valid), 32'h1);
        drive_cycles('0, 1'b1, 1'b1, 1);
        check_val("route2", 32'(up_resp_valid), 32'h8);
        drive_cycles('0, 1'b1, 1'b1, 1);
        check_val("route3", 32'(up_resp_valid), 32'h2);
        drain();

        // Randomized traffic with backpressure and config changes
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                cfg_prio_en         = 1'($urandom_range(0, 1));
                cfg_prio_port       = PORT_W'($urandom_range(0, NUM_PORTS - 1));
                cfg_max_outstanding = OUT_W'($urandom_range(0, 3));
            end
            cfg_enable = ($urandom_range(0, 9) != 0);
            drive_cycles(NUM_PORTS'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
                         ($urandom_range(0, 9) < 4), 1);
        end
        cfg_enable = 1'b1; cfg_prio_en = 1'b0; cfg_max_outstanding = '0;
        drain();

        // Response with empty FIFO
        up_req_valid = '0;
        mem_resp_valid = 1'b1;
        run_cycle();
        mem_resp_valid = 1'b0;
        check_val("underflow_flag", 32'(err_resp_underflow), 32'd1);
        check_val("underflow_no_resp", 32'(up_resp_valid), 32'd0);

        // Reset mid-burst
        drive_cycles('1, 1'b1, 1'b1, 5);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_mid");
        run_cycle();
        reset_n = 1'b1;
        up_req_valid = '0;
        mem_resp_valid = 1'b1;
        run_cycle();
        mem_resp_valid = 1'b0;
        check_val("post_reset_underflow", 32'(err_resp_underflow), 32'd1);
        run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
